// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//  rx_state_e : receiver FSM states
//  DATA_BITS  : payload bits per frame (8N1)
//  IDLE_LEVEL : level of an idle serial line
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO, head entry presented combinationally.
//  clk_i, rst_i : clock, asynchronous active-high reset
//  push_i/din_i : write request and data (accepted when not full, or when a pop frees a slot)
//  pop_i        : read request (ignored while empty)
//  dout_o       : head entry
//  count_o      : occupancy, full_o / empty_o status
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push_i & (~full_o | do_pop);

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Storage; cleared so the head reads zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with receive FIFO, sticky error flags and level interrupt.
//  wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//  rx_i               : asynchronous serial input, idle high
//  rx_data_o/rx_valid_o/rx_ready_i : FIFO head pop port
//  fifo_count_o       : FIFO occupancy
//  frame_err_o        : sticky, stop bit sampled low
//  overrun_o          : sticky, byte completed while FIFO full
//  clear_err_i        : clears both sticky flags (a simultaneous new error wins)
//  irq_o              : registered rx_valid_o | frame_err_o | overrun_o
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4167,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          rx_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    input  logic                          clear_err_i,
    output logic                          irq_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned LAST  = CLKS_PER_BIT - 1;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 push_q, push_d;
    logic                 frame_err_q, overrun_q, irq_q;
    logic                 sync1_q, sync2_q, rx_s_prev_q;
    logic                 rx_s, fall, mid, last;
    logic                 ferr_evt, ovr_evt;
    logic                 fifo_full, fifo_empty;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q     <= IDLE_LEVEL;
            sync2_q     <= IDLE_LEVEL;
            rx_s_prev_q <= IDLE_LEVEL;
        end else begin
            sync1_q     <= rx_i;
            sync2_q     <= sync1_q;
            rx_s_prev_q <= sync2_q;
        end
    end

    assign rx_s = sync2_q;
    assign fall = rx_s_prev_q & ~rx_s;
    assign mid  = (cnt_q == CNT_W'(HALF));
    assign last = (cnt_q == CNT_W'(LAST));

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            sh_q      <= '0;
            push_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            sh_q      <= sh_d;
            push_q    <= push_d;
        end
    end

    // Next-state logic. Every bit is sampled at its midpoint; START and DATA
    // run their full bit period so the next state is entered on a bit boundary,
    // while STOP leaves at mid-bit to be ready for a back-to-back start edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        sh_d      = sh_q;
        push_d    = 1'b0;
        ferr_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (mid && rx_s) begin
                    // Line back high mid start bit: glitch, drop silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (last) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (mid) begin
                    sh_d[bit_idx_q] = rx_s;
                end
                if (last) begin
                    cnt_d = '0;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (mid) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_evt = 1'b1;
                        state_d  = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A full FIFO with no simultaneous pop cannot take the byte.
    assign ovr_evt = push_q & fifo_full & ~rx_ready_i;

    // Sticky flags (set wins over clear) and registered interrupt.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            frame_err_q <= ferr_evt | (frame_err_q & ~clear_err_i);
            overrun_q   <= ovr_evt | (overrun_q & ~clear_err_i);
            irq_q       <= ~fifo_empty | frame_err_q | overrun_q;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push_q),
        .din_i   (sh_q),
        .pop_i   (rx_ready_i),
        .dout_o  (rx_data_o),
        .count_o (fifo_count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx_valid_o  = ~fifo_empty;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: queue-based reference model checked every cycle,
// plus directed frames with literal expectations.
module tb_uart_rx_core;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    // Cycles from driving the start bit to the FIFO count changing:
    // 2 sync + 1 edge register, start + 8 data bits whole, half the stop bit,
    // 1 push register, 1 FIFO write.
    localparam int PUSH_LAT = 3 + 9 * CPB + CPB / 2 + 2;

    logic       clk = 1'b0;
    logic       wb_rst_i, rx_i, rx_ready_i, clear_err_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, frame_err_o, overrun_o, irq_o;
    logic [2:0] fifo_count_o;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (wb_rst_i),
        .rx_i         (rx_i),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .fifo_count_o (fifo_count_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .clear_err_i  (clear_err_i),
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected frame outcomes: cycle of effect, byte, stop-bit error.
    int         pend_cyc  [64];
    logic [7:0] pend_byte [64];
    bit         pend_err  [64];
    int         pend_wr = 0;
    int         pend_rd = 0;

    // Reference state.
    logic [7:0] mq[$];
    bit         m_fe  = 0;
    bit         m_ov  = 0;
    bit         m_irq = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit do_pop, do_push, fe_ev, ov_ev, irq_n;
        logic [7:0] b;
        do_push = 0; fe_ev = 0; ov_ev = 0; b = 8'h00;
        if (wb_rst_i) begin
            mq.delete();
            m_fe = 0; m_ov = 0; m_irq = 0;
            pend_rd = pend_wr;
        end else begin
            irq_n  = (mq.size() != 0) | m_fe | m_ov;
            do_pop = rx_ready_i && (mq.size() != 0);
            if (pend_rd != pend_wr && pend_cyc[pend_rd] == cyc) begin
                if (pend_err[pend_rd]) fe_ev = 1;
                else begin do_push = 1; b = pend_byte[pend_rd]; end
                pend_rd++;
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < DEPTH) mq.push_back(b);
                else ov_ev = 1;
            end
            m_fe  = fe_ev | (m_fe & ~clear_err_i);
            m_ov  = ov_ev | (m_ov & ~clear_err_i);
            m_irq = irq_n;
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(rx_valid_o), 32'(mq.size() != 0));
        check("count", 32'(fifo_count_o), 32'(mq.size()));
        if (mq.size() != 0) check("data", 32'(rx_data_o), 32'(mq[0]));
        check("frame_err", 32'(frame_err_o), 32'(m_fe));
        check("overrun", 32'(overrun_o), 32'(m_ov));
        check("irq", 32'(irq_o), 32'(m_irq));
    endtask

    task automatic run_model();
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #2;
            compare_all();
        end
    endtask

    // Send one frame starting at the current negedge.
    // mode 1: pop during the push cycle; mode 2: clear_err during the error cycle.
    task automatic tx(input logic [7:0] b, input logic stop_lvl, input int mode);
        int c0;
        logic [9:0] fr;
        fr = {stop_lvl, b, 1'b0};
        c0 = cyc;
        pend_cyc[pend_wr]  = stop_lvl ? c0 + PUSH_LAT : c0 + PUSH_LAT - 1;
        pend_byte[pend_wr] = b;
        pend_err[pend_wr]  = !stop_lvl;
        pend_wr++;
        for (int i = 0; i < 10 * CPB; i++) begin
            rx_i        = fr[i / CPB];
            rx_ready_i  = (mode == 1) && (cyc == c0 + PUSH_LAT - 1);
            clear_err_i = (mode == 2) && (cyc == c0 + PUSH_LAT - 2);
            @(negedge clk);
        end
        rx_ready_i  = 1'b0;
        clear_err_i = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop(input logic [7:0] exp);
        check("pop_data", 32'(rx_data_o), 32'(exp));
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_err();
        clear_err_i = 1'b1;
        @(negedge clk);
        clear_err_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] seq2 [5];
        logic [7:0] c3;
        seq2 = '{8'h0F, 8'hA5, 8'h00, 8'hFF, 8'h11};
        wb_rst_i = 1'b1; rx_i = 1'b1; rx_ready_i = 1'b0; clear_err_i = 1'b0;
        fork run_model(); join_none
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rx_valid_o), 0);
        check("rst_data", 32'(rx_data_o), 0);
        check("rst_count", 32'(fifo_count_o), 0);
        check("rst_irq", 32'(irq_o), 0);
        check("rst_flags", {30'd0, frame_err_o, overrun_o}, 0);
        wb_rst_i = 1'b0;
        idle(5);

        // 1: single byte
        tx(8'h3D, 1'b1, 0);
        idle(4);
        check("t1_valid", 32'(rx_valid_o), 1);
        check("t1_data", 32'(rx_data_o), 32'h3D);
        check("t1_count", 32'(fifo_count_o), 1);
        check("t1_irq", 32'(irq_o), 1);
        pop(8'h3D);
        idle(4);
        check("t1_irq_low", 32'(irq_o), 0);

        // 2: overrun, fifth byte dropped
        for (int i = 0; i < 5; i++) begin
            tx(seq2[i], 1'b1, 0);
            idle(4);
        end
        check("t2_count", 32'(fifo_count_o), 4);
        check("t2_overrun", 32'(overrun_o), 1);
        for (int i = 0; i < 4; i++) pop(seq2[i]);
        check("t2_empty", 32'(fifo_count_o), 0);
        clear_err();
        idle(4);
        check("t2_ov_clr", 32'(overrun_o), 0);
        check("t2_irq_clr", 32'(irq_o), 0);

        // 3: frame error (clear in the same cycle loses), break, then good byte
        tx(8'h55, 1'b0, 2);
        rx_i = 1'b0;
        repeat (40) @(negedge clk);
        idle(20);
        check("t3_ferr", 32'(frame_err_o), 1);
        check("t3_nopush", 32'(fifo_count_o), 0);
        tx(8'h12, 1'b1, 0);
        idle(4);
        check("t3_data", 32'(rx_data_o), 32'h12);
        pop(8'h12);
        clear_err();
        idle(4);
        check("t3_ferr_clr", 32'(frame_err_o), 0);

        // 4: 4-clock glitch is ignored
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        idle(30);
        check("t4_nopush", 32'(fifo_count_o), 0);
        check("t4_noflags", {30'd0, frame_err_o, overrun_o}, 0);
        tx(8'h81, 1'b1, 0);
        idle(4);
        check("t4_data", 32'(rx_data_o), 32'h81);
        pop(8'h81);

        // 5: pop coincident with push into a full FIFO
        for (int i = 1; i <= 4; i++) begin
            tx(8'(i), 1'b1, 0);
            idle(4);
        end
        tx(8'h05, 1'b1, 1);
        idle(4);
        check("t5_overrun", 32'(overrun_o), 0);
        check("t5_count", 32'(fifo_count_o), 4);
        for (int i = 2; i <= 5; i++) pop(8'(i));

        // 6: reset mid-frame discards the partial byte
        c3 = 8'hC3;
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_i = c3[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = c3[3];
        repeat (CPB / 2) @(negedge clk);
        wb_rst_i = 1'b1;
        rx_i = 1'b1;
        repeat (5) @(negedge clk);
        wb_rst_i = 1'b0;
        idle(20);
        check("t6_empty", 32'(fifo_count_o), 0);
        clear_err();
        tx(8'h7E, 1'b1, 0);
        idle(4);
        check("t6_count", 32'(fifo_count_o), 1);
        check("t6_data", 32'(rx_data_o), 32'h7E);
        check("t6_irq", 32'(irq_o), 1);
        pop(8'h7E);
        idle(4);
        check("t6_irq_low", 32'(irq_o), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
